// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and defaults for the UART command-frame parser.
// UART_CMD_CHECKSUM_EN adds the checksum state to the FSM enum.
package uart_cmd_parser_pkg;

  localparam int         DEF_MAX_LEN     = 8;
  localparam int         DEF_TIMEOUT_CYC = 5000000;
  localparam logic [7:0] DEF_SYNC_BYTE   = 8'hAA;

`ifdef UART_CMD_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } parser_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3
  } parser_state_e;
`endif

  function automatic logic [7:0] xor_acc(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte timeout: counts enabled cycles without a clear and pulses expired
// on the TIMEOUT_CYC-th one; a clear in that same cycle suppresses the pulse.
module uart_byte_timeout
  import uart_cmd_parser_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int               CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_r;

  // Idle-cycle counter, saturating at the expiry value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clear || !enable) begin
      cnt_r <= '0;
    end else if (cnt_r != LIMIT) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = enable && !clear && (cnt_r == LIMIT);

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses SYNC/CMD/LEN/payload frames from a byte stream into registered commands.
// Define UART_CMD_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int         MAX_LEN     = DEF_MAX_LEN,
  parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_data_ready,
  output logic [7:0]           cmd_code,
  output logic [3:0]           cmd_len,
  output logic [8*MAX_LEN-1:0] cmd_payload,
  output logic                 cmd_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  parser_state_e        state_r;
  logic [3:0]           byte_cnt_r;
  logic [3:0]           len_r;
  logic [7:0]           code_r;
  logic [8*MAX_LEN-1:0] payload_buf_r;
  logic [8*MAX_LEN-1:0] payload_next_s;
  logic                 timeout_s;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]           csum_r;
`endif

  uart_byte_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (rx_data_ready),
    .enable  (state_r != ST_IDLE),
    .expired (timeout_s)
  );

  // Payload buffer with the incoming byte placed at the current index.
  always_comb begin
    payload_next_s = payload_buf_r;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (byte_cnt_r == 4'(i)) begin
        payload_next_s[i*8 +: 8] = rx_data;
      end else begin
        payload_next_s[i*8 +: 8] = payload_buf_r[i*8 +: 8];
      end
    end
  end

  // Frame FSM with registered command outputs and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      byte_cnt_r    <= 4'd0;
      len_r         <= 4'd0;
      code_r        <= 8'd0;
      payload_buf_r <= '0;
      cmd_code      <= 8'd0;
      cmd_len       <= 4'd0;
      cmd_payload   <= '0;
      cmd_valid     <= 1'b0;
      frame_err     <= 1'b0;
      busy          <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      csum_r        <= 8'd0;
`endif
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      if (rx_data_ready) begin
        case (state_r)
          ST_IDLE: begin
            // Non-sync bytes between frames are dropped without an error.
            if (rx_data == SYNC_BYTE) begin
              state_r       <= ST_CMD;
              busy          <= 1'b1;
              byte_cnt_r    <= 4'd0;
              len_r         <= 4'd0;
              payload_buf_r <= '0;
`ifdef UART_CMD_CHECKSUM_EN
              csum_r        <= 8'd0;
`endif
            end
          end
          ST_CMD: begin
            code_r  <= rx_data;
            state_r <= ST_LEN;
`ifdef UART_CMD_CHECKSUM_EN
            csum_r  <= xor_acc(csum_r, rx_data);
`endif
          end
          ST_LEN: begin
`ifdef UART_CMD_CHECKSUM_EN
            csum_r <= xor_acc(csum_r, rx_data);
`endif
            if (rx_data > MAX_LEN_B) begin
              state_r   <= ST_IDLE;
              busy      <= 1'b0;
              frame_err <= 1'b1;
            end else if (rx_data == 8'd0) begin
              len_r <= 4'd0;
`ifdef UART_CMD_CHECKSUM_EN
              state_r <= ST_CSUM;
`else
              state_r     <= ST_IDLE;
              busy        <= 1'b0;
              cmd_valid   <= 1'b1;
              cmd_code    <= code_r;
              cmd_len     <= 4'd0;
              cmd_payload <= '0;
`endif
            end else begin
              len_r   <= rx_data[3:0];
              state_r <= ST_DATA;
            end
          end
          ST_DATA: begin
            payload_buf_r <= payload_next_s;
            byte_cnt_r    <= byte_cnt_r + 4'd1;
`ifdef UART_CMD_CHECKSUM_EN
            csum_r        <= xor_acc(csum_r, rx_data);
`endif
            if (byte_cnt_r == (len_r - 4'd1)) begin
`ifdef UART_CMD_CHECKSUM_EN
              state_r <= ST_CSUM;
`else
              state_r     <= ST_IDLE;
              busy        <= 1'b0;
              cmd_valid   <= 1'b1;
              cmd_code    <= code_r;
              cmd_len     <= len_r;
              cmd_payload <= payload_next_s;
`endif
            end
          end
`ifdef UART_CMD_CHECKSUM_EN
          ST_CSUM: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            if (rx_data == csum_r) begin
              cmd_valid   <= 1'b1;
              cmd_code    <= code_r;
              cmd_len     <= len_r;
              cmd_payload <= payload_buf_r;
            end else begin
              frame_err <= 1'b1;
            end
          end
`endif
          default: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end else if (timeout_s) begin
        state_r   <= ST_IDLE;
        busy      <= 1'b0;
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench: directed frames plus random traffic against a
// frame-level reference model (checksum handling follows UART_CMD_CHECKSUM_EN).
module tb_uart_cmd_parser;

  localparam int         MAX_LEN = 8;
  localparam int         TO      = 100;
  localparam logic [7:0] SYNC    = 8'hAA;

  logic                 clk;
  logic                 rst_n;
  logic [7:0]           rx_data;
  logic                 rx_data_ready;
  logic [7:0]           cmd_code;
  logic [3:0]           cmd_len;
  logic [8*MAX_LEN-1:0] cmd_payload;
  logic                 cmd_valid;
  logic                 frame_err;
  logic                 busy;

  uart_cmd_parser #(
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TO),
    .SYNC_BYTE   (SYNC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_data),
    .rx_data_ready (rx_data_ready),
    .cmd_code      (cmd_code),
    .cmd_len       (cmd_len),
    .cmd_payload   (cmd_payload),
    .cmd_valid     (cmd_valid),
    .frame_err     (frame_err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Reference model state: bytes of the open frame after the sync marker.
  logic [7:0]           frm_q[$];
  logic                 in_frame;
  int                   idle_cnt;
  logic [7:0]           exp_code;
  logic [3:0]           exp_len;
  logic [8*MAX_LEN-1:0] exp_payload;
  logic                 exp_valid;
  logic                 exp_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".cmd_valid"}, 64'(cmd_valid), 64'(exp_valid));
    check({tag, ".frame_err"}, 64'(frame_err), 64'(exp_err));
    check({tag, ".busy"}, 64'(busy), 64'(in_frame));
    check({tag, ".cmd_code"}, 64'(cmd_code), 64'(exp_code));
    check({tag, ".cmd_len"}, 64'(cmd_len), 64'(exp_len));
    check({tag, ".cmd_payload"}, cmd_payload, exp_payload);
  endtask

  task automatic model_reset();
    in_frame    = 1'b0;
    idle_cnt    = 0;
    exp_code    = 8'd0;
    exp_len     = 4'd0;
    exp_payload = '0;
    exp_valid   = 1'b0;
    exp_err     = 1'b0;
    frm_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    int         n;
    int         need;
    logic       good;
    logic [7:0] x;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    idle_cnt  = 0;
    if (!in_frame) begin
      if (b == SYNC) begin
        in_frame = 1'b1;
        frm_q.delete();
      end
    end else begin
      frm_q.push_back(b);
      n = frm_q.size();
      if (n >= 2 && int'(frm_q[1]) > MAX_LEN) begin
        exp_err  = 1'b1;
        in_frame = 1'b0;
      end else if (n >= 2) begin
`ifdef UART_CMD_CHECKSUM_EN
        need = 3 + int'(frm_q[1]);
`else
        need = 2 + int'(frm_q[1]);
`endif
        if (n == need) begin
          good = 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
          x = 8'd0;
          for (int i = 0; i < n - 1; i++) x = x ^ frm_q[i];
          if (x != frm_q[n-1]) good = 1'b0;
`else
          x = 8'd0;
`endif
          if (good) begin
            exp_valid   = 1'b1;
            exp_code    = frm_q[0];
            exp_len     = frm_q[1][3:0];
            exp_payload = '0;
            for (int i = 0; i < int'(frm_q[1]); i++) exp_payload[i*8 +: 8] = frm_q[2+i];
          end else begin
            exp_err = 1'b1;
          end
          in_frame = 1'b0;
        end
      end
    end
  endtask

  // Called at a falling edge; drives one strobe cycle and checks the result.
  task automatic send_byte(input logic [7:0] b);
    rx_data       = b;
    rx_data_ready = 1'b1;
    @(negedge clk);
    rx_data_ready = 1'b0;
    rx_data       = 8'($urandom_range(0, 255));
    model_byte(b);
    check_outputs("byte");
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (in_frame) begin
        idle_cnt++;
        if (idle_cnt == TO) begin
          exp_err  = 1'b1;
          in_frame = 1'b0;
        end
      end
      check_outputs("idle");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         nn;
    int         kind;
    logic [7:0] b;
    logic [7:0] cmd;
    logic [7:0] len;
    logic [7:0] x;
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    rx_data       = 8'd0;
    rx_data_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Good frame, then the same frame with a corrupted trailing byte.
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h25);
    idle(2);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h26);
    idle(2);
    // Oversized length.
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h09);
    idle(1);
    // Leading noise and a zero-length frame.
    send_byte(8'h55); send_byte(8'h33);
    send_byte(8'hAA); send_byte(8'h07); send_byte(8'h00); send_byte(8'h07);
    idle(1);
    // Timeout expires after a stall.
    send_byte(8'hAA); send_byte(8'h01);
    idle(TO + 2);
    // A strobe in the expiry cycle wins over the timeout.
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02);
    idle(TO - 1);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h25);
    idle(2);
    // Reset mid-frame clears everything immediately.
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02); send_byte(8'h12);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'hAA); send_byte(8'h0C); send_byte(8'h03);
    send_byte(8'hAA); send_byte(8'h5A); send_byte(8'hFF);
    send_byte(8'h0C ^ 8'h03 ^ 8'hAA ^ 8'h5A ^ 8'hFF);
    idle(2);

    // Random traffic.
    for (int f = 0; f < 40; f++) begin
      nn = $urandom_range(0, 2);
      for (int k = 0; k < nn; k++) begin
        b = 8'($urandom_range(0, 255));
        if (b == SYNC) b = 8'h55;
        send_byte(b);
      end
      idle($urandom_range(0, 2));
      kind = $urandom_range(0, 4);
      cmd  = 8'($urandom_range(0, 255));
      if (kind == 0) len = 8'($urandom_range(MAX_LEN + 1, 255));
      else           len = 8'($urandom_range(0, MAX_LEN));
      send_byte(SYNC);
      send_byte(cmd);
      send_byte(len);
      x = cmd ^ len;
      if (kind != 0) begin
        for (int p = 0; p < int'(len); p++) begin
          b = 8'($urandom_range(0, 255));
          x = x ^ b;
          send_byte(b);
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        if (kind == 1) x = x ^ 8'h01;
        send_byte(x);
      end
      idle($urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum payload bytes per frame (1..15).
REQ-002 Parameter TIMEOUT_CYC, default 5000000: inter-byte timeout in clk cycles (100 ms at 50 MHz).
REQ-003 Parameter SYNC_BYTE, default 8'hAA: frame start marker.
REQ-004 clk  in  1  50 MHz system clock; single clock domain.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 rx_data  in  8  received byte; valid only in the cycle rx_data_ready is high.
REQ-007 rx_data_ready  in  1  one-cycle strobe per received byte.
REQ-008 cmd_code  out  8  command byte of the last good frame.
REQ-009 cmd_len  out  4  payload length of the last good frame.
REQ-010 cmd_payload  out  8*MAX_LEN  payload; byte 0 in bits [7:0]; unused bytes zero.
REQ-011 cmd_valid  out  1  one-cycle pulse when a good frame completes.
REQ-012 frame_err  out  1  one-cycle pulse on any frame abort.
REQ-013 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-014 Frame format: SYNC_BYTE, CMD, LEN, LEN payload bytes, then CHK if enabled (REQ-027).
REQ-015 FSM states: IDLE, CMD, LEN, DATA, CSUM; the FSM advances only on rx_data_ready.
REQ-016 IDLE: byte == SYNC_BYTE -> CMD; any other byte is discarded silently with no frame_err.
REQ-017 CMD: store the byte -> LEN.
REQ-018 LEN: LEN > MAX_LEN -> frame_err and IDLE; LEN == 0 -> CSUM, or complete if checksum disabled; otherwise -> DATA.
REQ-019 DATA: store the byte at index byte_cnt and increment; on the LEN-th byte -> CSUM, or complete if checksum disabled.
REQ-020 Running checksum is the 8-bit XOR of CMD, LEN and all payload bytes, cleared on entry to CMD.
REQ-021 CSUM: byte == running XOR -> complete; otherwise frame_err and IDLE.
REQ-022 Complete: in the cycle after the final byte's strobe, update cmd_code, cmd_len and cmd_payload together, pulse cmd_valid, and return to IDLE.
REQ-023 Outputs hold their values until the next good frame; aborted frames never modify cmd_* outputs.
REQ-024 Timeout: in any non-IDLE state, TIMEOUT_CYC cycles without a strobe -> frame_err and IDLE; the counter clears on every strobe.
REQ-025 If a strobe and timeout expiry occur in the same cycle, the strobe wins and no error is raised.
REQ-026 A SYNC_BYTE value seen mid-frame is treated as data; there is no resynchronisation.

Configuration
REQ-027 Macro UART_CMD_CHECKSUM_EN: when defined, the CSUM state and XOR logic exist; when undefined, the frame ends after the last payload byte (or after LEN when LEN == 0), and the CSUM state and XOR register are absent.

Reset
REQ-028 Asynchronous reset (rst_n low) sets FSM=IDLE and cmd_code=0, cmd_len=0, cmd_payload=0, cmd_valid=0, frame_err=0, busy=0; it also clears counters and the checksum.
REQ-029 Reset asserted mid-frame discards the partial frame with no pulse; after release, the next SYNC_BYTE starts a new frame.

Structure
REQ-030 A shared package holds the FSM state enum, the SYNC_BYTE default, the MAX_LEN default and the TIMEOUT_CYC default.
REQ-031 The timeout counter is one sub-module, uart_byte_timeout (inputs: clear, enable; output: expired pulse).

Verification
REQ-032 With checksum enabled, send AA 01 02 12 34 25 -> one cmd_valid pulse; cmd_code=01, cmd_len=2, cmd_payload[15:0]=16'h3412, upper bytes 0.
REQ-033 Send AA 01 02 12 34 26 -> frame_err pulse, no cmd_valid, and cmd_* keep their previous values.
REQ-034 Send AA 05 09 (with MAX_LEN=8) -> frame_err in the cycle after the LEN strobe; busy falls.
REQ-035 Send 55 33 AA 07 00 07 -> no error for 55 or 33; cmd_valid with cmd_code=07, cmd_len=0.
REQ-036 With TIMEOUT_CYC=100, send AA 01 and stall 100 cycles -> frame_err pulse; a strobe arriving exactly in the expiry cycle -> no error.
REQ-037 Pull rst_n low after AA 01 02 12 -> all outputs are 0 immediately; a following full valid frame is accepted normally.
